// File: rtl/cic_decim_param.sv
// CIC decimator: STAGES integrators at input rate, STAGES combs at decimated rate, rounding right-shift.
// Define CIC_SAT_EN to clamp out-of-range results and raise overflow; otherwise results wrap.
module cic_decim_param #(
  parameter int STAGES = 5,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = 88
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      dec_ratio,
  input  logic [6:0]       shift,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             overflow
);

  localparam int MAX_SH = ACC_W - OUT_W;

  logic [ACC_W-1:0] integ [STAGES];
  logic [ACC_W-1:0] z     [STAGES];
  logic [ACC_W-1:0] c     [STAGES+1];
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] cap;

  logic [15:0] count;
  logic [15:0] r_l;
  logic [15:0] r_cur;
  logic [15:0] ratio_eff;
  logic        armed;
  logic        strobe;
  logic        strobe_d;

  logic [31:0]             sh_eff;
  logic signed [ACC_W:0]   round_add;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   scaled;
  logic [OUT_W-1:0]        out_next;
  logic                    ovf_next;

  assign in_ext    = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign ratio_eff = (dec_ratio == 16'd0) ? 16'd1 : dec_ratio;
  // Until the first clock after reset release, the ratio comes straight from dec_ratio.
  assign r_cur     = armed ? r_l : ratio_eff;
  assign strobe    = in_valid && (count == r_cur - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + in_ext;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      r_l   <= 16'd1;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (!armed || strobe) r_l <= ratio_eff;
      if (strobe)        count <= '0;
      else if (in_valid) count <= count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap      <= '0;
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= strobe;
      if (strobe) cap <= integ[STAGES-1];
    end
  end

  always_comb begin
    c[0] = cap;
    for (int k = 0; k < STAGES; k++) c[k+1] = c[k] - z[k];
  end

  // One guard bit above ACC_W keeps the rounding add from flipping the sign.
  always_comb begin
    sh_eff    = ({25'd0, shift} > 32'(MAX_SH)) ? 32'(MAX_SH) : {25'd0, shift};
    round_add = '0;
    if (sh_eff != 32'd0) round_add = {{ACC_W{1'b0}}, 1'b1} << (sh_eff - 32'd1);
    rounded   = $signed({c[STAGES][ACC_W-1], c[STAGES]}) + round_add;
    scaled    = rounded >>> sh_eff;
  end

`ifdef CIC_SAT_EN
  logic sat_hi;
  logic sat_lo;

  always_comb begin
    sat_hi   = !scaled[ACC_W] && (|scaled[ACC_W-1:OUT_W-1]);
    sat_lo   = scaled[ACC_W] && !(&scaled[ACC_W-1:OUT_W-1]);
    ovf_next = sat_hi || sat_lo;
    if (sat_hi)      out_next = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) out_next = {1'b1, {(OUT_W-1){1'b0}}};
    else             out_next = scaled[OUT_W-1:0];
  end
`else
  always_comb begin
    out_next = OUT_W'(scaled);
    ovf_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) z[k] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= strobe_d;
      overflow  <= strobe_d && ovf_next;
      if (strobe_d) begin
        for (int k = 0; k < STAGES; k++) z[k] <= c[k];
        out_data <= out_next;
      end
    end
  end

endmodule
